// File: rtl/apb_coeff_pkg.sv
// Shared types and constants for the APB coefficient bank.
//   apb_state_e : APB slave FSM states
//   CTRL_*      : bit positions inside the per-channel control register
//   ch_bits/idx_bits : address field widths derived from NUM_CH / DEPTH
package apb_coeff_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_RD_ACT = 1;

    // A single channel still gets one address bit so the field is never empty.
    function automatic int ch_bits(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // DEPTH+1 guarantees the all-ones index (control register) lies above
    // the last coefficient.
    function automatic int idx_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/coeff_dbuf.sv
// One channel of double-buffered coefficients.
//   coef_we_i/idx_i/wdata_i : shadow coefficient write
//   ctrl_we_i/commit_i/rd_act_i : control register write
//   apply_en_i : datapath safe boundary; pending shadow is copied to active
//   rd_data_o  : shadow or active entry at idx_i, chosen by RD_ACT
//   coeff_o    : active bank, vld_o pulses for one cycle after an update
//   pending_o / rd_act_o : control register state
module coeff_dbuf
    import apb_coeff_pkg::*;
#(
    parameter int COEFF_WIDTH = 20,
    parameter int DEPTH       = 72,
    parameter int IDX_BITS    = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                apply_en_i,
    input  logic                                coef_we_i,
    input  logic [IDX_BITS-1:0]                 idx_i,
    input  logic [COEFF_WIDTH-1:0]              wdata_i,
    input  logic                                ctrl_we_i,
    input  logic                                commit_i,
    input  logic                                rd_act_i,
    output logic [COEFF_WIDTH-1:0]              rd_data_o,
    output logic [DEPTH-1:0][COEFF_WIDTH-1:0]   coeff_o,
    output logic                                vld_o,
    output logic                                pending_o,
    output logic                                rd_act_o
);

    logic [DEPTH-1:0][COEFF_WIDTH-1:0] shadow_q, active_q;
    logic pending_q, pending_d, rd_act_q, vld_q;
    logic apply;

    assign apply = apply_en_i & pending_q;

    // A commit landing on the apply cycle re-arms the channel.
    always_comb begin
        pending_d = pending_q;
        if (apply)
            pending_d = 1'b0;
        if (ctrl_we_i && commit_i)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            rd_act_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            if (coef_we_i)
                shadow_q[idx_i] <= wdata_i;
            // Copies the pre-edge shadow, so a same-cycle write waits for
            // the next commit.
            if (apply)
                active_q <= shadow_q;
            if (ctrl_we_i)
                rd_act_q <= rd_act_i;
            pending_q <= pending_d;
            vld_q     <= apply;
        end
    end

    assign rd_data_o = rd_act_q ? active_q[idx_i] : shadow_q[idx_i];
    assign coeff_o   = active_q;
    assign vld_o     = vld_q;
    assign pending_o = pending_q;
    assign rd_act_o  = rd_act_q;

endmodule

// File: rtl/apb_coeff_bank.sv
// APB3 slave exposing NUM_CH double-buffered coefficient banks.
//   clk, rst_n          : clock, async active-low reset
//   PSEL..PWDATA        : APB3 request; PADDR = {0.., ch, idx}
//   PRDATA/PREADY/PSLVERR : APB3 response
//   APPLY_EN            : datapath boundary where pending commits take effect
//   COEFF_OUT/COEFF_VLD : active coefficients and per-channel update pulse
//   PENDING             : per-channel commit waiting for APPLY_EN
module apb_coeff_bank
    import apb_coeff_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 72,
    parameter int WAIT_STATES = 0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           PSEL,
    input  logic                                           PENABLE,
    input  logic                                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]                          PADDR,
    input  logic [PDATA_WIDTH-1:0]                         PWDATA,
    output logic [PDATA_WIDTH-1:0]                         PRDATA,
    output logic                                           PREADY,
    output logic                                           PSLVERR,
    input  logic                                           APPLY_EN,
    output logic [NUM_CH-1:0][DEPTH-1:0][COEFF_WIDTH-1:0]  COEFF_OUT,
    output logic [NUM_CH-1:0]                              COEFF_VLD,
    output logic [NUM_CH-1:0]                              PENDING
);

    localparam int CH_BITS  = ch_bits(NUM_CH);
    localparam int IDX_BITS = idx_bits(DEPTH);
    localparam int CTRL_IDX = (1 << IDX_BITS) - 1;

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [PDATA_WIDTH-1:0] prdata_q;
    logic pslverr_q, capture;

    // ---- decode ----
    logic [CH_BITS-1:0]  ch;
    logic [IDX_BITS-1:0] idx;
    logic is_coef, is_ctrl, err, wr_ok;

    assign ch      = PADDR[IDX_BITS +: CH_BITS];
    assign idx     = PADDR[IDX_BITS-1:0];
    assign is_coef = 32'(idx) < DEPTH;
    assign is_ctrl = idx == IDX_BITS'(CTRL_IDX);
    assign err     = (|(PADDR >> (IDX_BITS + CH_BITS))) || !(32'(ch) < NUM_CH)
                     || !(is_coef || is_ctrl);
    assign wr_ok   = PSEL && PENABLE && PREADY && PWRITE && !err;

    // ---- per-channel banks ----
    logic [NUM_CH-1:0][COEFF_WIDTH-1:0] ch_rd;
    logic [NUM_CH-1:0] rd_act;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;
        assign sel = ch == CH_BITS'(g);
        coeff_dbuf #(
            .COEFF_WIDTH (COEFF_WIDTH),
            .DEPTH       (DEPTH),
            .IDX_BITS    (IDX_BITS)
        ) u_dbuf (
            .clk        (clk),
            .rst_n      (rst_n),
            .apply_en_i (APPLY_EN),
            .coef_we_i  (wr_ok && is_coef && sel),
            .idx_i      (idx),
            .wdata_i    (PWDATA[COEFF_WIDTH-1:0]),
            .ctrl_we_i  (wr_ok && is_ctrl && sel),
            .commit_i   (PWDATA[CTRL_COMMIT]),
            .rd_act_i   (PWDATA[CTRL_RD_ACT]),
            .rd_data_o  (ch_rd[g]),
            .coeff_o    (COEFF_OUT[g]),
            .vld_o      (COEFF_VLD[g]),
            .pending_o  (PENDING[g]),
            .rd_act_o   (rd_act[g])
        );
    end

    // ---- read mux ----
    logic [PDATA_WIDTH-1:0] rdata;
    logic signed [COEFF_WIDTH-1:0] coef_s;

    always_comb begin
        rdata  = '0;
        coef_s = ch_rd[ch];
        if (!err && !PWRITE) begin
            if (is_ctrl) begin
                rdata[CTRL_COMMIT] = PENDING[ch];
                rdata[CTRL_RD_ACT] = rd_act[ch];
            end else begin
                rdata = PDATA_WIDTH'(coef_s);
            end
        end
    end

    // ---- APB FSM ----
    // capture marks the cycle before PREADY rises, so the response is
    // already registered when the master samples it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                    capture = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    capture = (cnt_q == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                prdata_q  <= rdata;
                pslverr_q <= err;
            end
        end
    end

    assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_coeff_bank.sv
module tb_apb_coeff_bank;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int CW  = 20;
    localparam int NCH = 4;
    localparam int DEP = 72;
    localparam int WS  = 0;

    logic clk, rst_n, PSEL, PENABLE, PWRITE, APPLY_EN;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic PREADY, PSLVERR;
    logic [NCH-1:0][DEP-1:0][CW-1:0] COEFF_OUT;
    logic [NCH-1:0] COEFF_VLD, PENDING;

    apb_coeff_bank #(
        .ADDR_WIDTH(AW), .PDATA_WIDTH(DW), .COEFF_WIDTH(CW),
        .NUM_CH(NCH), .DEPTH(DEP), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .APPLY_EN(APPLY_EN),
        .COEFF_OUT(COEFF_OUT), .COEFF_VLD(COEFF_VLD), .PENDING(PENDING)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] a(input int ch, input int idx);
        return AW'(ch * 128 + idx);
    endfunction

    // Monitor: every completing transfer is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && PSEL && PENABLE && PREADY) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got response with empty queue, expected none");
            end else begin
                mon_e = q.pop_front();
                chk({mon_e.name, "_slverr"}, 64'(PSLVERR), 64'(mon_e.err));
                if (mon_e.chk_data)
                    chk({mon_e.name, "_prdata"}, 64'(PRDATA), 64'(mon_e.data));
            end
        end
    end

    // One APB transfer; optionally raises APPLY_EN in the completing cycle.
    task automatic apb(input string nm, input logic wr, input int ch, input int idx,
                       input logic [31:0] wd, input logic [31:0] exp_d,
                       input logic exp_e, input logic apply);
        exp_t e;
        int n;
        e.name = nm; e.chk_data = !wr; e.data = exp_d; e.err = exp_e;
        q.push_back(e);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a(ch, idx); PWDATA = wd;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        n = 0;
        while (!PREADY && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!PREADY) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no PREADY after %0d cycles, expected %0d", nm, n, WS);
            void'(q.pop_back());
        end else begin
            chk({nm, "_waits"}, 64'(n), 64'(WS));
        end
        APPLY_EN = apply;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; APPLY_EN = 1'b0;
    endtask

    task automatic wr(input string nm, input int ch, input int idx, input logic [31:0] d,
                      input logic exp_e);
        apb(nm, 1'b1, ch, idx, d, 32'h0, exp_e, 1'b0);
    endtask

    task automatic rd(input string nm, input int ch, input int idx, input logic [31:0] d,
                      input logic exp_e);
        apb(nm, 1'b0, ch, idx, 32'h0, d, exp_e, 1'b0);
    endtask

    task automatic pulse_apply();
        @(posedge clk); #1; APPLY_EN = 1'b1;
        @(posedge clk); #1; APPLY_EN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; APPLY_EN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready",  64'(PREADY), 64'(0));
        chk("rst_prdata",  64'(PRDATA), 64'(0));
        chk("rst_pslverr", 64'(PSLVERR), 64'(0));
        chk("rst_pending", 64'(PENDING), 64'(0));
        chk("rst_vld",     64'(COEFF_VLD), 64'(0));
        chk("rst_coeff0",  64'(COEFF_OUT == '0), 64'(1));
        rst_n = 1'b1;

        // shadow write / readback; active untouched
        wr("wr_c1i5", 1, 5, 32'h000FFFFF, 1'b0);
        rd("rd_c1i5", 1, 5, 32'hFFFFFFFF, 1'b0);
        chk("act_c1i5_pre", 64'(COEFF_OUT[1][5]), 64'(0));

        // commit held off until APPLY_EN
        wr("commit_c1", 1, 127, 32'h1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("pend_hold", 64'(PENDING), 64'(4'b0010));
        chk("act_hold",  64'(COEFF_OUT[1][5]), 64'(0));
        chk("vld_hold",  64'(COEFF_VLD), 64'(0));
        rd("rd_ctrl_c1", 1, 127, 32'h1, 1'b0);
        pulse_apply();
        chk("act_c1i5", 64'(COEFF_OUT[1][5]), 64'(20'hFFFFF));
        chk("vld_c1",   64'(COEFF_VLD), 64'(4'b0010));
        chk("pend_clr", 64'(PENDING), 64'(0));
        @(posedge clk); #1;
        chk("vld_pulse_end", 64'(COEFF_VLD), 64'(0));

        // RD_ACT selects active bank for readback
        wr("rdact_c1", 1, 127, 32'h2, 1'b0);
        wr("wr_c1i5_b", 1, 5, 32'h00000010, 1'b0);
        rd("rd_act_c1i5", 1, 5, 32'hFFFFFFFF, 1'b0);
        rd("rd_ctrl_act", 1, 127, 32'h2, 1'b0);
        wr("rdsh_c1", 1, 127, 32'h0, 1'b0);
        rd("rd_sh_c1i5", 1, 5, 32'h00000010, 1'b0);

        // illegal addresses
        wr("wr_idx72", 1, 72, 32'h123, 1'b1);
        rd("rd_idx72", 1, 72, 32'h0, 1'b1);
        wr("wr_ch4", 4, 5, 32'h456, 1'b1);
        rd("rd_ch4", 4, 5, 32'h0, 1'b1);
        rd("rd_idx100", 0, 100, 32'h0, 1'b1);
        rd("rd_c1i5_intact", 1, 5, 32'h00000010, 1'b0);
        rd("rd_ctrl_c0", 0, 127, 32'h0, 1'b0);
        chk("pend_after_err", 64'(PENDING), 64'(0));

        // shadow write coinciding with apply: active gets old shadow
        wr("wr_c2i0", 2, 0, 32'h0007FFFF, 1'b0);
        wr("commit_c2", 2, 127, 32'h1, 1'b0);
        apb("wr_c2i0_apply", 1'b1, 2, 0, 32'h00000123, 32'h0, 1'b0, 1'b1);
        chk("act_c2i0_old", 64'(COEFF_OUT[2][0]), 64'(20'h7FFFF));
        chk("vld_c2_a", 64'(COEFF_VLD), 64'(4'b0100));
        chk("pend_c2_a", 64'(PENDING), 64'(0));

        // commit coinciding with apply of a pending channel: re-armed
        wr("commit_c2_b", 2, 127, 32'h1, 1'b0);
        apb("commit_c2_apply", 1'b1, 2, 127, 32'h1, 32'h0, 1'b0, 1'b1);
        chk("act_c2i0_new", 64'(COEFF_OUT[2][0]), 64'(20'h00123));
        chk("vld_c2_b", 64'(COEFF_VLD), 64'(4'b0100));
        chk("pend_c2_rearm", 64'(PENDING), 64'(4'b0100));
        pulse_apply();
        chk("vld_c2_c", 64'(COEFF_VLD), 64'(4'b0100));
        chk("pend_c2_c", 64'(PENDING), 64'(0));
        pulse_apply();
        chk("vld_none", 64'(COEFF_VLD), 64'(0));
        chk("act_c2i0_keep", 64'(COEFF_OUT[2][0]), 64'(20'h00123));

        // reset during an access cycle
        wr("commit_c0", 0, 127, 32'h1, 1'b0);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a(1, 5);
        @(posedge clk); #1;
        PENABLE = 1'b1;
        chk("pre_rst_prdata", 64'(PRDATA), 64'(32'h10));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pready",  64'(PREADY), 64'(0));
        chk("mid_rst_prdata",  64'(PRDATA), 64'(0));
        chk("mid_rst_pending", 64'(PENDING), 64'(0));
        chk("mid_rst_coeff",   64'(COEFF_OUT == '0), 64'(1));
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        rst_n = 1'b1;
        rd("rd_c1i5_rst", 1, 5, 32'h0, 1'b0);
        rd("rd_ctrl_c1_rst", 1, 127, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
